// File: rtl/mux4_bus_arbiter_if.sv
// Bus bundle between four requesters and the shared 4:1 x 32-bit select mux arbiter.
// Handshake: a requester holds REQ[i] while it wants the mux. GNT[i] (registered, one-hot) marks
// ownership. The owner ends its turn by pulsing DONE[i] or dropping REQ[i]. SEL follows the owner.
interface mux4_bus_arbiter_if;
    logic [3:0] REQ;
    logic [3:0] DONE;
    logic [3:0] GNT;
    logic [1:0] SEL;
    logic       BUSY;

    modport master (output REQ, DONE, input GNT, SEL, BUSY);
    modport slave  (input REQ, DONE, output GNT, SEL, BUSY);
endinterface

// File: rtl/mux4_bus_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux with bounded hold time and one idle
// settle cycle between owners; SEL drives the mux select directly from the owner index.
module mux4_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                     CLK,
    input  logic                     Reset,
    mux4_bus_arbiter_if.slave        bus,
    output logic                     dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;

    logic       found;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       release_now;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b00;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        found       = 1'b0;
        pick        = 2'b00;
        idx         = 2'b00;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                // Search starts at ptr and wraps, so the last owner is visited last.
                for (int k = 0; k < 4; k++) begin
                    idx = ptr_q + 2'(k);
                    if (!found && bus.REQ[idx]) begin
                        found = 1'b1;
                        pick  = idx;
                    end
                end
                if (found) begin
                    gnt_d   = 4'b0001 << pick;
                    sel_d   = pick;
                    ptr_d   = pick + 2'd1;
                    cnt_d   = 8'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                release_now = bus.DONE[sel_q] || !bus.REQ[sel_q] || (cnt_q == HOLD_LAST);
                if (release_now) begin
                    gnt_d   = 4'b0000;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.GNT   = gnt_q;
    assign bus.SEL   = sel_q;
    assign bus.BUSY  = |gnt_q;
    assign dbg_state = state_q;

endmodule
